// File: rtl/demux12_buf_pkg.sv
// Shared constants for the buffered 1-to-2 nibble demultiplexer.
// Default geometry and channel select encodings.
package demux12_buf_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Pointer width, kept at least 1 bit for a degenerate depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/demux12_buf_fifo2.sv
// Single-channel synchronous FIFO used per demux output.
// Head word is forced to zero whenever the FIFO is empty.
module demux_fifo2
    import demux12_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_valid = (r_cnt != '0);
    assign w_push  = push & ~w_full;
    assign w_pop   = pop & w_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign dout  = w_valid ? r_mem[r_rptr] : '0;
    assign valid = w_valid;
    assign full  = w_full;

endmodule

// File: rtl/demux12_buf.sv
// Buffered 1-to-2 demux: routes each word by sel into one of two FIFOs.
// in_ready depends only on sel and the registered full flags.
module demux12_buf
    import demux12_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready
);

    logic w_full0;
    logic w_full1;
    logic w_take;
    logic w_push0;
    logic w_push1;

    // Any non-1 sel (X/Z) steers to channel 0 only, never both.
    assign in_ready = (sel === CH1) ? ~w_full1 : ~w_full0;
    assign w_take   = in_valid & in_ready;
    assign w_push0  = w_take & (sel !== CH1);
    assign w_push1  = w_take & (sel === CH1);

    demux_fifo2 #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo0 (
        .clk  (clk),
        .rst_n(rst_n),
        .push (w_push0),
        .din  (in),
        .pop  (out0_ready),
        .dout (out0),
        .valid(out0_valid),
        .full (w_full0)
    );

    demux_fifo2 #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo1 (
        .clk  (clk),
        .rst_n(rst_n),
        .push (w_push1),
        .din  (in),
        .pop  (out1_ready),
        .dout (out1),
        .valid(out1_valid),
        .full (w_full1)
    );

endmodule

// File: tb/tb_demux12_buf.sv
// Directed bench for demux12_buf: routing, backpressure, wrap, reset.
// Expected values are hand-computed constants per step.
module tb_demux12_buf;

    logic       clk;
    logic       rst_n;
    logic [3:0] in;
    logic       sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out1;
    logic       out1_valid;
    logic       out1_ready;

    int n_chk;
    int n_fail;

    demux12_buf #(.WIDTH(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1      (out1),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in         = 4'h0;
        sel        = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // 1: reset then idle
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_v0", 8'(out0_valid), 8'h0);
        chk("rst_v1", 8'(out1_valid), 8'h0);
        chk("rst_o0", 8'(out0), 8'h0);
        chk("rst_o1", 8'(out1), 8'h0);
        sel = 1'b0;
        #1;
        chk("rst_rdy_s0", 8'(in_ready), 8'h1);
        sel = 1'b1;
        #1;
        chk("rst_rdy_s1", 8'(in_ready), 8'h1);

        // 2: routing and latency
        in = 4'hA; sel = 1'b0; in_valid = 1'b1;
        tick();
        chk("rt_o0", 8'(out0), 8'hA);
        chk("rt_v0", 8'(out0_valid), 8'h1);
        chk("rt_v1_idle", 8'(out1_valid), 8'h0);
        chk("rt_o1_idle", 8'(out1), 8'h0);
        in = 4'h5; sel = 1'b1;
        tick();
        chk("rt_o1", 8'(out1), 8'h5);
        chk("rt_v1", 8'(out1_valid), 8'h1);
        chk("rt_o0_hold", 8'(out0), 8'hA);
        in_valid = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        chk("rt_drain_v0", 8'(out0_valid), 8'h0);
        chk("rt_drain_v1", 8'(out1_valid), 8'h0);
        chk("rt_drain_o0", 8'(out0), 8'h0);
        out0_ready = 1'b0; out1_ready = 1'b0;

        // 3: full backpressure
        in = 4'h1; sel = 1'b0; in_valid = 1'b1;
        #1;
        chk("bp_rdy1", 8'(in_ready), 8'h1);
        tick();
        in = 4'h2;
        tick();
        in = 4'h3;
        #1;
        chk("bp_full_rdy", 8'(in_ready), 8'h0);
        tick();
        chk("bp_head", 8'(out0), 8'h1);
        chk("bp_still_full", 8'(in_ready), 8'h0);
        chk("bp_ch1_empty", 8'(out1_valid), 8'h0);
        sel = 1'b1;
        #1;
        chk("bp_rdy_s1", 8'(in_ready), 8'h1);
        tick();
        chk("bp_o1", 8'(out1), 8'h3);
        chk("bp_v1", 8'(out1_valid), 8'h1);
        chk("bp_o0_hold", 8'(out0), 8'h1);
        in_valid = 1'b0;

        // 4: full plus simultaneous pop
        in = 4'h7; sel = 1'b0; in_valid = 1'b1; out0_ready = 1'b1;
        #1;
        chk("fp_rdy0", 8'(in_ready), 8'h0);
        tick();
        chk("fp_head2", 8'(out0), 8'h2);
        chk("fp_rdy1", 8'(in_ready), 8'h1);
        out0_ready = 1'b0;
        tick();
        chk("fp_head2b", 8'(out0), 8'h2);
        chk("fp_full", 8'(in_ready), 8'h0);
        in_valid = 1'b0; out0_ready = 1'b1;
        tick();
        chk("fp_head7", 8'(out0), 8'h7);
        chk("fp_v7", 8'(out0_valid), 8'h1);
        tick();
        chk("fp_empty", 8'(out0_valid), 8'h0);
        chk("fp_o0_zero", 8'(out0), 8'h0);
        out0_ready = 1'b0; out1_ready = 1'b1;
        tick();
        chk("fp_ch1_empty", 8'(out1_valid), 8'h0);
        out1_ready = 1'b0;

        // 5: wrap-around streaming
        out0_ready = 1'b1; sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in = 4'(i);
            #1;
            chk("st_rdy", 8'(in_ready), 8'h1);
            tick();
            chk("st_o0", 8'(out0), 8'(i));
            chk("st_v0", 8'(out0_valid), 8'h1);
        end
        in_valid = 1'b0;
        tick();
        chk("st_end_v0", 8'(out0_valid), 8'h0);
        out0_ready = 1'b0;

        // 6: reset mid-operation
        in_valid = 1'b1; sel = 1'b0; in = 4'hC;
        tick();
        in = 4'hD;
        tick();
        sel = 1'b1; in = 4'hE;
        tick();
        in_valid = 1'b0;
        chk("mr_o0", 8'(out0), 8'hC);
        chk("mr_o1", 8'(out1), 8'hE);
        sel = 1'b0;
        #1;
        chk("mr_full0", 8'(in_ready), 8'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_v0", 8'(out0_valid), 8'h0);
        chk("mr_v1", 8'(out1_valid), 8'h0);
        chk("mr_o0z", 8'(out0), 8'h0);
        chk("mr_o1z", 8'(out1), 8'h0);
        chk("mr_rdy0", 8'(in_ready), 8'h1);
        in = 4'h9; sel = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_o1_9", 8'(out1), 8'h9);
        chk("mr_v1_9", 8'(out1_valid), 8'h1);
        chk("mr_v0_off", 8'(out0_valid), 8'h0);
        out1_ready = 1'b1;
        tick();
        chk("mr_o1_drain", 8'(out1_valid), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
